// File: rtl/led_scroll_sequencer.sv
// Run-time controller for the 8-LED red/green scroll display: accepts a configuration
// over valid/ready, then rotates or bounces the pattern at the programmed step rate.
module led_scroll_sequencer #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [7:0]       cfg_pattern,
    input  logic [1:0]       cfg_color,
    input  logic [1:0]       cfg_mode,
    input  logic [DIV_W-1:0] cfg_period,
    input  logic [3:0]       cfg_passes,
    input  logic             stop,
    output logic [7:0]       red_out,
    output logic [7:0]       green_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [7:0]       pat;
    logic [1:0]       color;
    logic [1:0]       mode;
    logic [DIV_W-1:0] period;
    logic [3:0]       passes;
    logic [DIV_W-1:0] cnt;
    logic [6:0]       steps;
    logic             dir;

    logic [7:0]       nxt_pat;
    logic             nxt_dir;
    logic             step_due;
    logic             last_step;

    assign red_out   = color[0] ? pat : '0;
    assign green_out = color[1] ? pat : '0;
    assign cfg_ready = (state == IDLE);
    assign busy      = (state == RUN);

    assign step_due  = (cnt == period);
    // One pass is 8 steps; passes == 0 never completes.
    assign last_step = (passes != 4'd0) && ((steps + 7'd1) == {passes, 3'b000});

    always_comb begin
        nxt_pat = pat;
        nxt_dir = dir;
        case (mode)
            2'b00: nxt_pat = pat;
            2'b01: nxt_pat = {pat[6:0], pat[7]};
            2'b10: nxt_pat = {pat[0], pat[7:1]};
            2'b11: begin
                // Bounce: reverse at an edge; a pattern touching both edges cannot move.
                if (!(pat[7] & pat[0])) begin
                    if (!dir) begin
                        if (pat[0]) begin
                            nxt_dir = 1'b1;
                            nxt_pat = pat << 1;
                        end else begin
                            nxt_pat = pat >> 1;
                        end
                    end else begin
                        if (pat[7]) begin
                            nxt_dir = 1'b0;
                            nxt_pat = pat >> 1;
                        end else begin
                            nxt_pat = pat << 1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pat    <= 8'hC0;
            color  <= 2'b01;
            mode   <= '0;
            period <= '0;
            passes <= '0;
            cnt    <= '0;
            steps  <= '0;
            dir    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (cfg_valid) begin
                    pat    <= cfg_pattern;
                    color  <= cfg_color;
                    mode   <= cfg_mode;
                    period <= cfg_period;
                    passes <= cfg_passes;
                    cnt    <= '0;
                    steps  <= '0;
                    dir    <= 1'b0;
                    state  <= RUN;
                end
            end else begin
                // A completing step outranks stop; otherwise stop suppresses the step.
                if (step_due && last_step) begin
                    pat   <= nxt_pat;
                    dir   <= nxt_dir;
                    cnt   <= '0;
                    steps <= steps + 7'd1;
                    done  <= 1'b1;
                    state <= IDLE;
                end else if (stop) begin
                    state <= IDLE;
                end else if (step_due) begin
                    pat   <= nxt_pat;
                    dir   <= nxt_dir;
                    cnt   <= '0;
                    steps <= steps + 7'd1;
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule
